// File: rtl/sigma_pkg.sv
// Shared types and slot-offset helpers for the unscented-transform sigma point stage.
package sigma_pkg;

    localparam int FP_W     = 64;
    localparam int SIGN_BIT = 63;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int point_offset(input int size, input int k, input int i);
        return FP_W * (k * size + i);
    endfunction

    function automatic int factor_offset(input int size, input int r, input int c);
        return FP_W * (r * size + c);
    endfunction

endpackage

// File: rtl/sigma_points_fp64_add.sv
// Double-precision adder wrapper: one combinational add with round-to-nearest-even,
// followed by a fixed-depth register pipeline carrying result and valid.
module fp64_add #(
    parameter int LATENCY = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        in_valid,
    output logic [63:0] result,
    output logic        out_valid
);

    localparam logic [63:0] QUIET_BIT = 64'h0008_0000_0000_0000;
    localparam logic [63:0] DEF_NAN   = 64'h7ff8_0000_0000_0000;

    function automatic logic [5:0] clz56(input logic [55:0] v);
        logic [5:0] n;
        logic       found;
        n     = 6'd56;
        found = 1'b0;
        for (int k = 55; k >= 0; k--) begin
            if (!found && v[k]) begin
                n     = 6'(55 - k);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    logic         a_nan, b_nan, a_inf, b_inf, a_big, res_sign, rnd;
    logic [63:0]  x, y, sum_bits;
    logic [52:0]  sx, sy;
    logic [11:0]  ex, ey, d, ex_n, lz_lim;
    logic [5:0]   dsh, lz;
    logic [119:0] wide;
    logic [55:0]  mx, my, diff, mn;
    logic [56:0]  sum;
    logic [10:0]  e_field;
    logic [62:0]  packed_v;

    always_comb begin
        a_nan = (a[62:52] == 11'h7ff) && (a[51:0] != 52'd0);
        b_nan = (b[62:52] == 11'h7ff) && (b[51:0] != 52'd0);
        a_inf = (a[62:52] == 11'h7ff) && (a[51:0] == 52'd0);
        b_inf = (b[62:52] == 11'h7ff) && (b[51:0] == 52'd0);

        // x always carries the larger magnitude so the difference is never negative
        a_big = a[62:0] >= b[62:0];
        x     = a_big ? a : b;
        y     = a_big ? b : a;
        sx    = {(x[62:52] != 11'd0), x[51:0]};
        sy    = {(y[62:52] != 11'd0), y[51:0]};
        ex    = (x[62:52] == 11'd0) ? 12'd1 : {1'b0, x[62:52]};
        ey    = (y[62:52] == 11'd0) ? 12'd1 : {1'b0, y[62:52]};

        d    = ex - ey;
        dsh  = (d > 12'd63) ? 6'd63 : d[5:0];
        wide = {sy, 3'b000, 64'd0} >> dsh;
        mx   = {sx, 3'b000};
        my   = {wide[119:65], wide[64] | (|wide[63:0])};

        sum  = {1'b0, mx} + {1'b0, my};
        diff = mx - my;
        lz   = clz56(diff);

        mn       = '0;
        ex_n     = ex;
        lz_lim   = '0;
        res_sign = x[63];
        if (x[63] == y[63]) begin
            if (sum[56]) begin
                mn   = {sum[56:2], sum[1] | sum[0]};
                ex_n = ex + 12'd1;
            end else begin
                mn = sum[55:0];
            end
        end else begin
            // normalise, but never below the subnormal exponent
            lz_lim = ({6'd0, lz} > (ex - 12'd1)) ? (ex - 12'd1) : {6'd0, lz};
            mn     = diff << lz_lim;
            ex_n   = ex - lz_lim;
            if (diff == 56'd0) res_sign = 1'b0;
        end

        e_field  = mn[55] ? ex_n[10:0] : 11'd0;
        rnd      = mn[2] & (mn[1] | mn[0] | mn[3]);
        packed_v = {e_field, mn[54:3]} + 63'(rnd);

        if (ex_n >= 12'd2047) sum_bits = {res_sign, 11'h7ff, 52'd0};
        else                  sum_bits = {res_sign, packed_v};

        if (a_nan)                             sum_bits = a | QUIET_BIT;
        else if (b_nan)                        sum_bits = b | QUIET_BIT;
        else if (a_inf && b_inf && a[63] != b[63]) sum_bits = DEF_NAN;
        else if (a_inf)                        sum_bits = a;
        else if (b_inf)                        sum_bits = b;
    end

    logic [63:0]        res_pipe [LATENCY];
    logic [LATENCY-1:0] vld_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int s = 0; s < LATENCY; s++) res_pipe[s] <= '0;
        end else begin
            vld_pipe[0] <= in_valid;
            res_pipe[0] <= sum_bits;
            for (int s = 1; s < LATENCY; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                res_pipe[s] <= res_pipe[s-1];
            end
        end
    end

    assign result    = res_pipe[LATENCY-1];
    assign out_valid = vld_pipe[LATENCY-1];

endmodule

// File: rtl/sigma_points.sv
// Sigma point generator: chi0 = x, chi(j+1) = x + L[:,j], chi(n+j+1) = x - L[:,j],
// all sums issued one per cycle into a shared pipelined double adder.
//
// state | meaning
// IDLE  | waiting for enable; sigma/ready hold the last result set
// ISSUE | one adder op per cycle, column outer, row inner, plus then minus
// DRAIN | waiting for in-flight results to land before raising ready
module sigma_points
    import sigma_pkg::*;
#(
    parameter int SIZE        = 3,
    parameter int ADD_LATENCY = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic [FP_W*SIZE-1:0]              mean,
    input  logic [FP_W*SIZE*SIZE-1:0]         factor,
    output logic [FP_W*SIZE*(2*SIZE+1)-1:0]   sigma,
    output logic                              ready
);

    localparam int N_OPS = 2 * SIZE * SIZE;
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int PT_W  = $clog2(2 * SIZE + 1);
    localparam int OPS_W = $clog2(N_OPS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SIZE - 1);

    state_t                   state;
    logic [FP_W*SIZE-1:0]     mean_q;
    logic [FP_W*SIZE*SIZE-1:0] factor_q;
    logic [IDX_W-1:0]         col, row;
    logic                     minus;
    logic [OPS_W-1:0]         ops_left;

    logic                     issue, pipe_busy, add_valid;
    logic [FP_W-1:0]          op_a, op_b, add_result;
    logic [PT_W-1:0]          op_pt;

    logic [PT_W-1:0]          tag_pt [ADD_LATENCY];
    logic [IDX_W-1:0]         tag_el [ADD_LATENCY];
    logic [ADD_LATENCY-1:0]   tag_vld;

    assign issue     = (state == ISSUE);
    assign pipe_busy = |tag_vld;

    // Upper-triangle entries are treated as zero, so the minus op sees -0 and returns mean exactly
    always_comb begin
        op_a = mean_q[FP_W*int'(row) +: FP_W];
        op_b = '0;
        if (row >= col) op_b = factor_q[factor_offset(SIZE, int'(row), int'(col)) +: FP_W];
        if (minus) op_b[SIGN_BIT] = ~op_b[SIGN_BIT];
        op_pt = minus ? PT_W'(SIZE + 1 + int'(col)) : PT_W'(int'(col) + 1);
    end

    fp64_add #(
        .LATENCY (ADD_LATENCY)
    ) u_add (
        .clk       (clk),
        .rst       (rst),
        .a         (op_a),
        .b         (op_b),
        .in_valid  (issue),
        .result    (add_result),
        .out_valid (add_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld <= '0;
            for (int s = 0; s < ADD_LATENCY; s++) begin
                tag_pt[s] <= '0;
                tag_el[s] <= '0;
            end
        end else begin
            tag_vld[0] <= issue;
            tag_pt[0]  <= op_pt;
            tag_el[0]  <= row;
            for (int s = 1; s < ADD_LATENCY; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_pt[s]  <= tag_pt[s-1];
                tag_el[s]  <= tag_el[s-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ready    <= 1'b0;
            sigma    <= '0;
            mean_q   <= '0;
            factor_q <= '0;
            col      <= '0;
            row      <= '0;
            minus    <= 1'b0;
            ops_left <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        mean_q                <= mean;
                        factor_q              <= factor;
                        sigma[FP_W*SIZE-1:0]  <= mean;
                        ready                 <= 1'b0;
                        col                   <= '0;
                        row                   <= '0;
                        minus                 <= 1'b0;
                        ops_left              <= OPS_W'(N_OPS - 1);
                        state                 <= ISSUE;
                    end
                end
                ISSUE: begin
                    minus <= ~minus;
                    if (minus) begin
                        if (row == IDX_LAST) begin
                            row <= '0;
                            col <= col + 1'b1;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                    if (ops_left == '0) state <= DRAIN;
                    else                ops_left <= ops_left - 1'b1;
                end
                DRAIN: begin
                    if (!pipe_busy) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (add_valid)
                sigma[point_offset(SIZE, int'(tag_pt[ADD_LATENCY-1]), int'(tag_el[ADD_LATENCY-1])) +: FP_W]
                    <= add_result;
        end
    end

endmodule
